// File: rtl/byte_distributor_1t8.sv
// byte_distributor_1t8: takes a valid/ready byte stream and scatters each byte
// into one of NCH registered lanes, either at an explicit address or at an
// auto-incrementing write pointer. Once every lane has been written the block
// pulses frame_done and holds off the source until the consumer acknowledges.
module byte_distributor_1t8 #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [SW-1:0]                in_addr,
    input  logic                         addr_mode,
    input  logic                         frame_ack,
    output logic [(2**SW)*WIDTH-1:0]     o_all,
    output logic [(2**SW)-1:0]           wr_mask,
    output logic [SW-1:0]                wr_ptr,
    output logic                         frame_done
);

    localparam int NCH = 2**SW;
    localparam logic [SW-1:0] PTR_ONE = SW'(1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NCH*WIDTH-1:0]    r_lanes;
    logic [NCH-1:0]          r_mask;
    logic [SW-1:0]           r_ptr;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_rearm;
    logic [SW-1:0]           w_tgt;
    logic [NCH-1:0]          w_onehot;
    logic [NCH-1:0]          w_mask_next;
    logic                    w_fill_to_full;

    // Ready is purely combinational so clr and rst block a beat in the same cycle.
    assign in_ready = (r_state == ST_FILL) & ~clr & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_rearm  = (r_state == ST_FULL) & frame_ack & ~clr;
    assign w_tgt    = addr_mode ? r_ptr : in_addr;

    // Decode the target lane and form the mask as it will look after this beat.
    always_comb begin
        w_onehot        = '0;
        w_onehot[w_tgt] = 1'b1;
        w_mask_next     = r_mask;
        if (w_accept) begin
            w_mask_next = r_mask | w_onehot;
        end
    end

    // Next-state logic; clr dominates, then frame_ack re-arm, then fill completion.
    always_comb begin
        w_state_next   = r_state;
        w_fill_to_full = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (w_accept && (&w_mask_next)) begin
                    w_state_next   = ST_FULL;
                    w_fill_to_full = 1'b1;
                end
            end
            ST_FULL: begin
                if (frame_ack) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
        if (clr) begin
            w_state_next   = ST_FILL;
            w_fill_to_full = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lane storage, written-lane mask, auto pointer and the frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lanes <= '0;
            r_mask  <= '0;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else if (clr) begin
            r_lanes <= '0;
            r_mask  <= '0;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fill_to_full;
            if (w_rearm) begin
                r_mask <= '0;
                r_ptr  <= '0;
            end else if (w_accept) begin
                r_lanes[w_tgt*WIDTH +: WIDTH] <= in_data;
                r_mask                         <= w_mask_next;
                if (addr_mode) begin
                    r_ptr <= r_ptr + PTR_ONE;
                end
            end
        end
    end

    assign o_all      = r_lanes;
    assign wr_mask    = r_mask;
    assign wr_ptr     = r_ptr;
    assign frame_done = r_done;

endmodule

// File: tb/tb_byte_distributor_1t8.sv
// Testbench for byte_distributor_1t8: scripted scenarios plus random traffic,
// checked through a scoreboard fed by an array-based reference model.
module tb_byte_distributor_1t8;

    localparam int WIDTH = 8;
    localparam int SW    = 3;
    localparam int NCH   = 8;

    logic                    clk;
    logic                    rst;
    logic                    clr;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [SW-1:0]           in_addr;
    logic                    addr_mode;
    logic                    frame_ack;
    logic [NCH*WIDTH-1:0]    o_all;
    logic [NCH-1:0]          wr_mask;
    logic [SW-1:0]           wr_ptr;
    logic                    frame_done;

    byte_distributor_1t8 #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .addr_mode  (addr_mode),
        .frame_ack  (frame_ack),
        .o_all      (o_all),
        .wr_mask    (wr_mask),
        .wr_ptr     (wr_ptr),
        .frame_done (frame_done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 rdy;
        logic [NCH*WIDTH-1:0] all;
        logic [NCH-1:0]       mask;
        logic [SW-1:0]        ptr;
        logic                 done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: plain arrays describing the lanes and which were filled.
    logic [7:0] m_lane [NCH];
    bit         m_written [NCH];
    int         m_ptr  = 0;
    bit         m_full = 0;
    bit         m_done = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, logic [2:0] a, bit m,
                                       bit ack, bit c, bit r, output exp_t e);
        int k;
        int cnt;
        e.rdy = !m_full && !c && !r;
        if (r || c) begin
            for (int i = 0; i < NCH; i++) begin
                m_lane[i]    = 8'h00;
                m_written[i] = 0;
            end
            m_ptr  = 0;
            m_full = 0;
            m_done = 0;
        end else if (m_full) begin
            m_done = 0;
            if (ack) begin
                m_full = 0;
                m_ptr  = 0;
                for (int i = 0; i < NCH; i++) m_written[i] = 0;
            end
        end else begin
            m_done = 0;
            if (v) begin
                k            = m ? m_ptr : int'(a);
                m_lane[k]    = d;
                m_written[k] = 1;
                if (m) m_ptr = (m_ptr + 1) % NCH;
                cnt = 0;
                for (int i = 0; i < NCH; i++) cnt += int'(m_written[i]);
                if (cnt == NCH) begin
                    m_full = 1;
                    m_done = 1;
                end
            end
        end
        e.all  = '0;
        e.mask = '0;
        for (int i = 0; i < NCH; i++) begin
            e.all[i*8 +: 8] = m_lane[i];
            e.mask[i]       = m_written[i];
        end
        e.ptr  = m_ptr[2:0];
        e.done = m_done;
    endfunction

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic drive(bit v, logic [7:0] d, logic [2:0] a, bit m,
                         bit ack, bit c, bit r);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_addr   = a;
        addr_mode = m;
        frame_ack = ack;
        clr       = c;
        model_step(v, d, a, m, ack, c, r, e);
        sb.push_back(e);
        if (r) begin
            #1 rst = 1'b1;
            #1;
            chk("async_rst_o_all", 64'(o_all), 64'h0);
            chk("async_rst_mask", 64'(wr_mask), 64'h0);
            chk("async_rst_ptr", 64'(wr_ptr), 64'h0);
            chk("async_rst_ready", 64'(in_ready), 64'h0);
        end else begin
            rst = 1'b0;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 3'd0, 0, 0, 0, 0);
    endtask

    // Monitor: sample ready before the edge, outputs after it, compare to scoreboard.
    initial begin
        logic rdy_s;
        exp_t e;
        forever begin
            @(negedge clk);
            #3 rdy_s = in_ready;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("in_ready", 64'(rdy_s), 64'(e.rdy));
                chk("o_all", o_all, e.all);
                chk("wr_mask", 64'(wr_mask), 64'(e.mask));
                chk("wr_ptr", 64'(wr_ptr), 64'(e.ptr));
                chk("frame_done", 64'(frame_done), 64'(e.done));
            end
        end
    end

    initial begin
        logic [2:0] addrs [9];
        logic [7:0] datas [9];
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        addr_mode = 1'b0;
        frame_ack = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_lane[i]    = 8'h00;
            m_written[i] = 0;
        end

        drive(0, 8'h00, 3'd0, 0, 0, 0, 1);
        idle(2);

        // Auto fill 0x10..0x17 back to back, then observe the stall.
        for (int k = 0; k < 8; k++) drive(1, 8'(8'h10 + k), 3'd0, 1, 0, 0, 0);
        idle(2);
        drive(0, 8'h00, 3'd0, 0, 1, 0, 0);

        // Explicit out-of-order writes including an overwrite of lane 3.
        addrs = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        for (int k = 0; k < 9; k++) datas[k] = {5'b10100, addrs[k]};
        datas[3] = 8'hB3;
        for (int k = 0; k < 9; k++) drive(1, datas[k], addrs[k], 0, 0, 0, 0);
        idle(1);
        drive(0, 8'h00, 3'd0, 0, 1, 0, 0);

        // Stall while full, ack together with valid, then first beat of next frame.
        for (int k = 0; k < 8; k++) drive(1, 8'(8'h20 + k), 3'd0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(1, 8'hEE, 3'd2, 1, 0, 0, 0);
        drive(1, 8'h77, 3'd0, 1, 1, 0, 0);
        drive(1, 8'h55, 3'd0, 1, 0, 0, 0);
        idle(1);

        // clr racing a write.
        drive(0, 8'h00, 3'd0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) drive(1, 8'(8'h30 + k), 3'd0, 1, 0, 0, 0);
        drive(1, 8'hFF, 3'd0, 1, 0, 1, 0);
        idle(1);

        // Asynchronous reset in the middle of a frame.
        for (int k = 0; k < 4; k++) drive(1, 8'(8'h40 + k), 3'd0, 1, 0, 0, 0);
        drive(1, 8'h99, 3'd0, 1, 0, 0, 1);
        idle(1);

        // Mixed mode: pointer wraps and lane 5 is overwritten by an auto beat.
        drive(1, 8'h60, 3'd0, 1, 0, 0, 0);
        drive(1, 8'h61, 3'd0, 1, 0, 0, 0);
        drive(1, 8'hC5, 3'd5, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) drive(1, 8'(8'h62 + k), 3'd0, 1, 0, 0, 0);
        idle(2);
        drive(0, 8'h00, 3'd0, 0, 1, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0));
        end
        idle(1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
